uart_rx_deserializer: RTL and testbench

//  UART receive path, the counterpart of the TX serializer. Oversamples serial line rx_in,

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_deserializer_if.sv | 38 +++
 rtl/uart_rx_sampler.sv | 85 ++++++++
 rtl/uart_rx_deserializer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared UART definitions used by the receive and transmit paths.
//            - rx_state_e : receive FSM state encoding
//            - PAR_EVEN / PAR_ODD : values of the par_typ control input
//            - maj3 : 2-of-3 majority vote used on bit samples
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deserializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : uart_rx_deserializer_if
//  Purpose : Bundles the serial line, the per-frame parity controls and the
//            host-side result strobes of the UART receiver.
//  Signals : rx_in      serial line, idle high
//            par_en     1 = frame carries a parity bit
//            par_typ    0 = even, 1 = odd
//            p_data     last good byte
//            data_valid 1-cycle pulse, p_data updated in the same cycle
//            par_err    1-cycle pulse, parity mismatch
//            stp_err    1-cycle pulse, stop bit sampled low
//  Modports: master = line/host driver side, slave = receiver
//  Rev     : 1.0  initial release
// ============================================================================
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output rx_in, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : uart_rx_sampler
//  Purpose : Line front end of the UART receiver. Synchronises rx_in with two
//            flops, runs the per-bit oversample counter while a frame is in
//            progress and majority-votes three samples taken around the bit
//            centre.
//  Ports   : clk, rst  clock / synchronous active-high reset
//            rx_in     asynchronous serial line
//            active    1 while the receiver is inside a frame; 0 holds the
//                      counter at zero
//            rx_s      synchronised line
//            bit_val   voted bit value (valid from bit_rdy onwards)
//            bit_rdy   pulse when the third sample arrives
//            bit_end   last oversample cycle of the bit period
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter  int OVERSAMPLE = 8,
    localparam int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic rx_in,
    input  wire logic active,
    output logic      rx_s,
    output logic      bit_val,
    output logic      bit_rdy,
    output logic      bit_end
);

    localparam int              c_mid     = OVERSAMPLE / 2;
    localparam logic [CNT_W-1:0] c_samp_lo = CNT_W'(c_mid - 1);
    localparam logic [CNT_W-1:0] c_samp_md = CNT_W'(c_mid);
    localparam logic [CNT_W-1:0] c_samp_hi = CNT_W'(c_mid + 1);
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_q,     sync_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]       samp_q,     samp_d;     // [0] at centre-1, [1] at centre
    logic             vote_q,     vote_d;
    logic             vote_w;

    assign rx_s = sync_q[1];

    // Third sample is the live synchronised line, so the vote is available
    // in the same cycle it is taken; it is then held for the rest of the bit.
    assign vote_w  = maj3(samp_q[0], samp_q[1], rx_s);
    assign bit_rdy = active && (edge_cnt_q == c_samp_hi);
    assign bit_end = active && (edge_cnt_q == c_last);
    assign bit_val = bit_rdy ? vote_w : vote_q;

    always_comb begin
        sync_d     = {sync_q[0], rx_in};
        edge_cnt_d = '0;
        samp_d     = samp_q;
        vote_d     = vote_q;

        if (active) begin
            edge_cnt_d = (edge_cnt_q == c_last) ? '0 : edge_cnt_q + CNT_W'(1);
            if (edge_cnt_q == c_samp_lo) samp_d[0] = rx_s;
            if (edge_cnt_q == c_samp_md) samp_d[1] = rx_s;
        end
        if (bit_rdy) vote_d = vote_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            edge_cnt_q <= '0;
            samp_q     <= '0;
            vote_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
            vote_q     <= vote_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : uart_rx_deserializer
//  Purpose : UART receive path. Detects the start bit, deserialises LSB-first
//            data, checks optional parity and the stop bit, and reports each
//            frame with a single registered strobe (data_valid, par_err and/or
//            stp_err) one cycle after the stop bit period ends.
//  Ports   : clk  single clock, posedge
//            rst  synchronous active-high reset
//            bus  uart_rx_deserializer_if.slave (rx_in, par_en, par_typ in;
//                 p_data, data_valid, par_err, stp_err out)
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    uart_rx_deserializer_if.slave   bus
);

    localparam int               c_bcnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(DATA_WIDTH - 1);

    rx_state_e               state_q,      state_d;
    logic [c_bcnt_w-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic                    par_flag_q,   par_flag_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;

    logic rx_s;
    logic bit_val;
    logic bit_rdy;
    logic bit_end;
    logic active;

    assign active = (state_q != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx_in   (bus.rx_in),
        .active  (active),
        .rx_s    (rx_s),
        .bit_val (bit_val),
        .bit_rdy (bit_rdy),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Parity controls are frozen here so mid-frame changes on
                // the inputs cannot affect the frame being received.
                if (!rx_s) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    par_en_d   = bus.par_en;
                    par_typ_d  = bus.par_typ;
                    par_flag_d = 1'b0;
                end
            end

            START: begin
                // A start bit that votes high was a line glitch.
                if (bit_end) state_d = bit_val ? IDLE : DATA;
            end

            DATA: begin
                // LSB arrives first, so shifting in at the top leaves the
                // byte correctly ordered after DATA_WIDTH bits.
                if (bit_rdy) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == c_last_bit) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_bcnt_w'(1);
                    end
                end
            end

            PARITY: begin
                // Expected parity bit: XOR of data for even, inverted for odd.
                if (bit_rdy && (bit_val != ((^shift_q) ^ par_typ_q))) par_flag_d = 1'b1;
                if (bit_end) state_d = STOP;
            end

            STOP: begin
                // bit_val still holds the stop-bit vote taken mid-bit.
                if (bit_end) begin
                    state_d = IDLE;
                    if (bit_val && !par_flag_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    par_err_d = par_flag_q;
                    stp_err_d = !bit_val;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_flag_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_flag_q   <= par_flag_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.p_data     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_uart_rx_deserializer
//  Purpose : Self-checking bench for uart_rx_deserializer. Frames are built
//            bit by bit on the line; the expected outcome of each frame is
//            derived from its fields and queued, and a monitor pops one entry
//            per observed strobe.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int OS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_deserializer #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp     = 0;
    int            n_bad     = 0;
    logic [DW-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: the frame outcome follows only from the bits placed
    // on the line. Even parity means the count of ones in data+parity is even.
    task automatic expect_frame(input logic [DW-1:0] data, input logic pen,
                                input logic par_bit, input logic ptyp,
                                input logic stop_bit);
        exp_t e;
        logic par_ok;
        par_ok = !pen || (par_bit == (logic'($countones(data) % 2) ^ ptyp));
        e.dv   = stop_bit && par_ok;
        e.pe   = !par_ok;
        e.se   = !stop_bit;
        if (e.dv) last_good = data;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    // Sends one frame. flip_par corrupts the parity bit, jitter stretches or
    // shrinks bit periods by one clock (cumulative drift kept within +/-1),
    // scramble toggles par_en/par_typ after the start bit.
    task automatic send_frame(input logic [DW-1:0] data, input logic pen,
                              input logic ptyp, input logic flip_par,
                              input logic stop_bit, input logic jitter,
                              input logic scramble);
        logic bits[$];
        logic par_bit;
        int   cum;
        int   j;
        par_bit = (logic'($countones(data) % 2) ^ ptyp) ^ flip_par;
        expect_frame(data, pen, par_bit, ptyp, stop_bit);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        bus.par_en  = pen;
        bus.par_typ = ptyp;
        cum = 0;
        for (int i = 0; i < bits.size(); i++) begin
            j = 0;
            if (jitter) begin
                j = int'($urandom_range(0, 2)) - 1;
                if ((cum + j > 1) || (cum + j < -1)) j = 0;
                cum += j;
            end
            if (scramble && i == 1) begin
                bus.par_en  = 1'($urandom_range(0, 1));
                bus.par_typ = 1'($urandom_range(0, 1));
            end
            bus.rx_in = bits[i];
            tick(OS + j);
        end
        bus.rx_in = 1'b1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_p_data_hold"}, bus.p_data, last_good);
        exp_q.delete();
    endtask

    // Monitor: every strobe cycle consumes exactly one expected frame outcome.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got dv=%0b pe=%0b se=%0b p_data=0x%0h, expected no strobe",
                         bus.data_valid, bus.par_err, bus.stp_err, bus.p_data);
            end else begin
                e = exp_q.pop_front();
                check("data_valid", bus.data_valid, e.dv);
                check("par_err",    bus.par_err,    e.pe);
                check("stp_err",    bus.stp_err,    e.se);
                check("p_data",     bus.p_data,     e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_in   = 1'b1;
        bus.par_en  = 1'b0;
        bus.par_typ = 1'b0;
        rst         = 1'b1;
        tick(3);
        check("reset_p_data",     bus.p_data,     0);
        check("reset_data_valid", bus.data_valid, 0);
        check("reset_par_err",    bus.par_err,    0);
        check("reset_stp_err",    bus.stp_err,    0);
        rst = 1'b0;
        tick(5);

        // No parity, clean frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        // Even parity good, then corrupted parity
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(4);
        // Odd parity correct, stop bit low
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4);
        drain("directed_a");

        // Short glitch on an idle line must not produce a frame
        bus.rx_in = 1'b0;
        tick(3);
        bus.rx_in = 1'b1;
        tick(20);
        check("glitch_no_strobe_q", exp_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Back-to-back frames with zero idle gap
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        drain("directed_b");

        // Reset in the middle of the data bits of 0x77
        bus.par_en = 1'b0;
        bus.rx_in  = 1'b0;
        tick(OS);
        bus.rx_in  = 1'b1;
        tick(OS);
        bus.rx_in  = 1'b1;
        tick(OS / 2);
        rst        = 1'b1;
        bus.rx_in  = 1'b1;
        tick(2);
        rst        = 1'b0;
        last_good  = '0;
        check("midframe_reset_p_data", bus.p_data, 0);
        tick(20);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(6);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(6);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(6);
        drain("directed_c");

        // Randomised frames: data, parity mode, corruptions and gaps
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                       1'b0, 1'b1);
            tick($urandom_range(0, 6));
        end
        tick(4);
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
